// File: rtl/shift64_pi_so_if.sv
// Control/data bundle between the frame controller and the PISO transmitter.
// master drives the request side, slave is the transmitter.
interface shift64_pi_so_if #(
  parameter int WIDTH = 64,
  parameter int FCNTW = 8
);
  logic             Start;
  logic             Abort;
  logic [WIDTH-1:0] Pi;
  logic             So;
  logic             LoadOut;
  logic             Busy;
  logic             Done;
  logic [FCNTW-1:0] FrameCnt;

  modport master (
    output Start, Abort, Pi,
    input  So, LoadOut, Busy, Done, FrameCnt
  );

  modport slave (
    input  Start, Abort, Pi,
    output So, LoadOut, Busy, Done, FrameCnt
  );
endinterface

// File: rtl/shift64_pi_so.sv
// Parallel-in/serial-out feeder for a downstream SIPO config chain, MSB first.
// Start accepted in IDLE only; LoadOut high WIDTH cycles, then a one-cycle Done pulse.
module shift64_pi_so #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7,
  parameter int FCNTW = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  shift64_pi_so_if.slave       bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [CNTW-1:0]   cnt_q;
  logic              so_q;
  logic              load_q;
  logic              busy_q;
  logic              done_q;
  logic [FCNTW-1:0]  fcnt_q;

  // shreg_q is kept left-aligned: its MSB is always the next bit to send.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            shreg_q <= {bus.Pi[WIDTH-2:0], 1'b0};
            so_q    <= bus.Pi[WIDTH-1];
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            so_q    <= 1'b0;
            load_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.Abort) begin
            so_q    <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == LAST) begin
            so_q    <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fcnt_q  <= fcnt_q + 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            so_q    <= shreg_q[WIDTH-1];
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.So       = so_q;
  assign bus.LoadOut  = load_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.FrameCnt = fcnt_q;

endmodule

// File: tb/tb_shift64_pi_so.sv
// Directed bench for shift64_pi_so with a SIPO receiver chain model.
module tb_shift64_pi_so;

  logic Clk;
  logic Reset;
  logic [63:0] chain;

  shift64_pi_so_if #(.WIDTH(64), .FCNTW(8)) bus ();

  shift64_pi_so #(.WIDTH(64), .CNTW(7), .FCNTW(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Receiver chain: shifts on LoadOut, first bit in ends at the MSB.
  always @(posedge Clk) begin
    if (bus.LoadOut) chain <= {chain[62:0], bus.So};
  end

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [63:0] pi;
    bit          abort_idle;
    logic [7:0]  exp_fcnt;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " So"}, 64'(bus.So), 64'd0);
    check({tag, " LoadOut"}, 64'(bus.LoadOut), 64'd0);
    check({tag, " Busy"}, 64'(bus.Busy), 64'd0);
    check({tag, " Done"}, 64'(bus.Done), 64'd0);
  endtask

  // Count LoadOut-high cycles starting from the accept cycle; stop when it drops.
  task automatic count_load(output int n);
    n = 1;
    while (bus.LoadOut && n < 200) begin
      tick();
      if (bus.LoadOut) n++;
    end
  endtask

  task automatic do_frame(input logic [63:0] pi, input bit abort_idle,
                          input logic [7:0] exp_fc, input string tag);
    int n;
    bus.Pi    = pi;
    bus.Abort = abort_idle;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Pi    = ~pi;
    check({tag, " busy after start"}, 64'(bus.Busy), 64'd1);
    count_load(n);
    check({tag, " loadout cycles"}, 64'(n), 64'd64);
    check({tag, " done"}, 64'(bus.Done), 64'd1);
    check({tag, " busy in done"}, 64'(bus.Busy), 64'd0);
    check({tag, " chain"}, chain, pi);
    check({tag, " framecnt"}, 64'(bus.FrameCnt), 64'(exp_fc));
    tick();
    check({tag, " done cleared"}, 64'(bus.Done), 64'd0);
  endtask

  task automatic fast_frame();
    int n;
    bus.Pi    = 64'h0F0F_0F0F_0F0F_0F0F;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    n = 0;
    while (!bus.Done && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("fast frame timeout", 64'(n), 64'd64);
    tick();
  endtask

  initial begin
    int n;
    logic [63:0] cur_exp;
    logic [63:0] aa;
    logic [63:0] ff55;

    vecs[0] = '{64'hDEAD_BEEF_0123_4567, 1'b0, 8'd1};
    vecs[1] = '{64'h0000_0000_0000_0000, 1'b0, 8'd2};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'd3};
    vecs[3] = '{64'h8000_0000_0000_0001, 1'b0, 8'd4};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b0, 8'd5};
    aa   = 64'hAAAA_AAAA_AAAA_AAAA;
    ff55 = 64'h5555_5555_5555_5555;

    // Reset
    Reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Pi    = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset framecnt", 64'(bus.FrameCnt), 64'd0);
    Reset = 1'b1;
    tick();
    check_idle_outputs("post reset");

    // Single frames, including Abort+Start in IDLE (Start wins)
    for (int i = 0; i < 5; i++)
      do_frame(vecs[i].pi, vecs[i].abort_idle, vecs[i].exp_fcnt, $sformatf("vec%0d", i));

    // Start held high: back-to-back frames with one LoadOut-low cycle between
    bus.Pi    = aa;
    bus.Start = 1'b1;
    tick();
    cur_exp = aa;
    bus.Pi  = ff55;
    for (int f = 0; f < 3; f++) begin
      count_load(n);
      check($sformatf("b2b%0d loadout cycles", f), 64'(n), 64'd64);
      check($sformatf("b2b%0d done", f), 64'(bus.Done), 64'd1);
      check($sformatf("b2b%0d chain", f), chain, cur_exp);
      check($sformatf("b2b%0d framecnt", f), 64'(bus.FrameCnt), 64'(6 + f));
      if (f == 2) bus.Start = 1'b0;
      tick();
      check($sformatf("b2b%0d restart", f), 64'(bus.LoadOut), (f == 2) ? 64'd0 : 64'd1);
      cur_exp = bus.Pi;
      bus.Pi  = (bus.Pi == aa) ? ff55 : aa;
    end
    check("b2b end done", 64'(bus.Done), 64'd0);

    // Abort at cnt=10
    bus.Pi    = 64'h1111_2222_3333_4444;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (10) tick();
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check_idle_outputs("abort10");
    check("abort10 framecnt", 64'(bus.FrameCnt), 64'd8);
    tick();
    check("abort10 no late done", 64'(bus.Done), 64'd0);
    do_frame(64'hCAFE_F00D_1234_ABCD, 1'b0, 8'd9, "after abort10");

    // Abort at cnt=63 together with Start: abort wins, no Done
    bus.Pi    = 64'h5A5A_5A5A_A5A5_A5A5;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (63) tick();
    bus.Abort = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Abort = 1'b0;
    bus.Start = 1'b0;
    check_idle_outputs("abort63");
    check("abort63 framecnt", 64'(bus.FrameCnt), 64'd9);
    tick();
    check("abort63 stays idle", 64'(bus.Busy), 64'd0);
    do_frame(64'h0F1E_2D3C_4B5A_6978, 1'b0, 8'd10, "after abort63");

    // Asynchronous reset mid-frame at cnt=30
    bus.Pi    = 64'hFFFF_0000_FFFF_0000;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (30) tick();
    check("midframe loadout before reset", 64'(bus.LoadOut), 64'd1);
    #2 Reset = 1'b0;
    #1;
    check_idle_outputs("async reset");
    check("async reset framecnt", 64'(bus.FrameCnt), 64'd0);
    tick();
    Reset = 1'b1;
    tick();
    do_frame(64'h1, 1'b0, 8'd1, "after reset");

    // FrameCnt wrap
    for (int i = 0; i < 254; i++) fast_frame();
    check("framecnt 255", 64'(bus.FrameCnt), 64'd255);
    do_frame(64'h7654_3210_FEDC_BA98, 1'b0, 8'd0, "wrap");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
